// File: rtl/alu_pkg.sv
// Shared types for the sequenced ALU: opcode encoding, legal-op count and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  localparam int unsigned ALU_NUM_LEGAL_OPS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded in on start so the final bit is added when done_o is high.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      // counter indexes the bit being added; it stops at the last one
      if (cnt_q == CNT_LAST) busy_d = 1'b0;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus an
// optional iterative multiply. One operation in flight at most.
//   state | meaning
//   IDLE  | accepting; single-cycle ops load the output registers directly
//   MUL   | multiplier iterating, one bit per cycle
//   DONE  | product ready; load output registers and return to IDLE
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_out,
  output logic             overflow_flag,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] NUM_LEGAL = 4'(ALU_NUM_LEGAL_OPS);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, ill_q, ill_d;
  logic             out_valid_q, out_valid_d;

  alu_op_e          op;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic             accept, is_mul, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign op    = alu_op_e'(opcode);
  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = (opcode >= NUM_LEGAL) || ((op == ALU_MUL) && !MUL_EN);
    case (op)
      ALU_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      default:  alu_res = '0;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (op == ALU_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      res_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = MUL;
            mul_start = 1'b1;
          end else begin
            // a same-cycle consume is overridden here: new result replaces old
            res_d       = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) state_d = DONE;
      end
      DONE: begin
        res_d       = mul_prod[WIDTH-1:0];
        zero_d      = (mul_prod[WIDTH-1:0] == '0);
        carry_d     = |mul_prod[2*WIDTH-1:WIDTH];
        ovf_d       = 1'b0;
        ill_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (op_a),
        .b_i     (op_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  assign out_valid     = out_valid_q;
  assign result        = res_q;
  assign zero_flag     = zero_q;
  assign carry_out     = carry_q;
  assign overflow_flag = ovf_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32, MUL_EN=1); inputs driven and
// outputs sampled on the falling clock edge.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero_flag, carry_out, overflow_flag, illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero_flag     (zero_flag),
    .carry_out     (carry_out),
    .overflow_flag (overflow_flag),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flags packed as {zero, carry, overflow, illegal}
  task automatic run_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_res, input logic [3:0] e_flg);
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1; opcode = opc; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_res"}, result, e_res);
    check({tag, "_flg"}, {zero_flag, carry_out, overflow_flag, illegal_op}, e_flg);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_res, input logic e_c);
    int  lat;
    bit  rdy_seen;
    bit  done;
    lat = 0; rdy_seen = 0; done = 0;
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd10; op_a = a; op_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b0; op_a = ~a; op_b = 32'h5A5A_5A5A;
      end
      if (out_valid) begin
        lat = i; done = 1;
      end else if (in_ready) begin
        rdy_seen = 1;
      end
    end
    check({tag, "_lat"}, lat, 32);
    check({tag, "_busy_rdy"}, rdy_seen, 0);
    check({tag, "_res"}, result, e_res);
    check({tag, "_flg"}, {zero_flag, carry_out, overflow_flag, illegal_op},
          {(e_res == 32'h0), e_c, 1'b0, 1'b0});
  endtask

  initial begin
    bit stable;
    bit seen;

    @(negedge clk);
    check("rst_state", {out_valid, zero_flag, carry_out, overflow_flag, illegal_op, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", in_ready, 1);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1100);
    run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0010);
    run_op("sub_ovf",  4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0010);
    run_op("sub_brw",  4'd1, 32'h1, 32'h2, 32'hFFFF_FFFF, 4'b0100);
    run_op("or",       4'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0000);
    run_op("slt",      4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 4'b0000);
    run_op("sltu",     4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1000);
    run_op("sra",      4'd7, 32'h8000_0000, 32'h4, 32'hF800_0000, 4'b0000);
    run_op("srl",      4'd6, 32'h8000_0000, 32'h4, 32'h0800_0000, 4'b0000);
    run_op("sll",      4'd5, 32'h1, 32'd31, 32'h8000_0000, 4'b0000);
    run_op("sll_mask", 4'd5, 32'h1, 32'h0000_0021, 32'h2, 4'b0000);
    run_op("ill_f",    4'hF, 32'h1234, 32'h5678, 32'h0, 4'b1001);
    run_op("ill_b",    4'hB, 32'h1, 32'h1, 32'h0, 4'b1001);

    // back-to-back single-cycle ops
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd0; op_a = 32'd1; op_b = 32'd1;
    @(negedge clk);
    check("b2b_1", {out_valid, result}, {1'b1, 32'd2});
    opcode = 4'd3; op_a = 32'h0F; op_b = 32'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_2", {out_valid, result}, {1'b1, 32'hFF});

    run_mul("mul_big", 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    run_mul("mul_7x6", 32'd7, 32'd6, 32'd42, 1'b0);
    run_mul("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1);

    // backpressure: AND result held, pending XOR request waits
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd2;
    op_a = 32'hF0F0_1234; op_b = 32'h0FF0_FF00;
    @(negedge clk);
    opcode = 4'd4;
    check("bp_and", {out_valid, result}, {1'b1, 32'h00F0_1200});
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 32'h00F0_1200 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {zero_flag, carry_out, overflow_flag, illegal_op} !== 4'b0000) stable = 0;
    end
    check("bp_hold", stable, 1);
    out_ready = 1'b1;
    #1;
    check("bp_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_xor", {out_valid, result}, {1'b1, 32'hFF00_ED34});
    @(negedge clk);
    check("bp_drain", {out_valid, result}, {1'b0, 32'hFF00_ED34});

    // reset during multiply
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd10; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {out_valid, zero_flag, carry_out, overflow_flag, illegal_op, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_rdy", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("rst_no_stale", seen, 0);

    run_op("post_rst", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU with a valid/ready handshake on both input and output sides. Successor to the team's 32-bit combinational ALU.
- Adds shifts, signed/unsigned compares, signed overflow, an illegal-opcode flag and an iterative multi-cycle multiply.
- Sits between the operand-issue stage and the writeback stage. Holds at most one operation in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL is treated as an illegal opcode.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation this cycle.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B; for shifts, the shift amount is op_b[$clog2(WIDTH)-1:0].
- opcode  input  4  operation select (alu_pkg::alu_op_e).
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream consumes the result this cycle.
- result  output  WIDTH  operation result.
- zero_flag  output  1  result == 0.
- carry_out  output  1  carry / borrow / multiply-overflow indicator (per opcode).
- overflow_flag  output  1  signed overflow (ADD/SUB only).
- illegal_op  output  1  opcode was unsupported.

Behaviour:
- Reset (async assert, sync release): state = IDLE; out_valid = 0; result, all flags = 0; in_ready = 1 after release. Reset mid-MUL aborts the operation; no result is produced.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLL; 6 SRL; 7 SRA.
  - 8 SLT (signed), 9 SLTU: result = {0…, lt}.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11–15: result 0, illegal_op = 1.
- Flags:
  - ADD: carry_out = bit WIDTH of the unsigned sum.
  - SUB: carry_out = 1 on borrow (op_a < op_b unsigned).
  - overflow_flag: signed overflow, ADD/SUB only; 0 for all other opcodes.
  - MUL: carry_out = 1 iff the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - Logic, shift and compare ops: carry_out = 0.
  - zero_flag is computed from the registered result, including the illegal-op case (zero_flag = 1).
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready); allows back-to-back single-cycle ops at full throughput.
  - Output transfer happens when out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0: result and flags hold stable; in_ready = 0.
  - When out_valid = 0, result and flags hold their last values; they are not cleared.
- Latency:
  - Non-MUL ops: out_valid = 1 in the cycle after acceptance (1 cycle).
  - MUL: shift-add, one multiplier bit per cycle. out_valid rises exactly WIDTH cycles after acceptance.
- FSM:
  - IDLE -> MUL on acceptance of MUL; a non-MUL op writes the output registers directly and stays in IDLE.
  - MUL -> DONE when the iteration counter reaches WIDTH-1.
  - DONE: load the output registers, out_valid = 1, return to IDLE.
- Operands are captured at acceptance; input changes during MUL have no effect.
- Iteration counter is $clog2(WIDTH) bits and does not wrap within an operation.
- Shift amounts ≥ WIDTH cannot occur (amount field is masked to $clog2(WIDTH) bits). SRA replicates op_a[WIDTH-1].
- Simultaneous output consume and new accept in the same cycle: the new result replaces the old one; out_valid stays 1.

Decomposition:
- alu_pkg contains:
  - alu_op_e enum (4-bit) with the opcode values above.
  - ALU_NUM_LEGAL_OPS constant.
  - alu_state_e {IDLE, MUL, DONE}.
- Sub-module alu_mul_iter: inputs start, a, b; outputs done, prod[2·WIDTH-1:0]; holds the counter and accumulator. Instantiated only when MUL_EN = 1 (generate).

Test Plan:
- ADD 0xFFFF_FFFF + 0x1 -> result 0x0, zero 1, carry 1, overflow 0, out_valid exactly 1 cycle after accept.
- SUB 0x8000_0000 − 0x1 -> 0x7FFF_FFFF, overflow 1, carry 0. SLT 0xFFFF_FFFF vs 0x1 -> 1. SLTU with the same operands -> 0.
- SRA 0x8000_0000 by 4 -> 0xF800_0000. SRL by 4 -> 0x0800_0000. SLL 0x1 by 31 -> 0x8000_0000.
- MUL 0x0001_0000 × 0x0001_0000 -> result 0, carry 1, zero 1, latency 32 cycles, in_ready 0 throughout. MUL 7 × 6 -> 42, carry 0.
- Backpressure: out_ready held 0 for 5 cycles after an AND result -> result/flags stable, in_ready 0. Then out_ready = 1 with in_valid = 1 (XOR) -> consume and accept in the same cycle; the XOR result appears the next cycle.
- Opcode 0xF -> result 0, illegal_op 1, zero 1. Assert rst_n low at MUL cycle 10 -> all outputs 0 immediately; after release in_ready = 1 and no stale out_valid.
